// File: rtl/fir_stream_arbiter.sv
// Round-robin, packet-locked arbiter that lets several AXI4-Stream sources share one FIR datapath.
// Before each packet it spends one cycle pulsing fir_clear, so samples from one packet never leak into the next.
module fir_stream_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int CH_W   = 2
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic [NUM_CH-1:0]        s_axis_valid,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_data,
  input  logic [NUM_CH-1:0]        s_axis_last,
  output logic [NUM_CH-1:0]        s_axis_ready,
  output logic                     m_axis_valid,
  output logic [DATA_W-1:0]        m_axis_data,
  output logic                     m_axis_last,
  output logic [CH_W-1:0]          m_axis_id,
  input  logic                     m_axis_ready,
  output logic                     fir_clear,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   grant, grant_nxt;
  logic [CH_W-1:0]   last_grant, last_grant_nxt;
  logic [CH_W-1:0]   pick;
  logic              grant_live, grant_live_nxt;
  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant == CH_W'(k)) begin
        sel_valid = s_axis_valid[k];
        sel_last  = s_axis_last[k];
        sel_data  = s_axis_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // The search runs from the farthest offset down to the nearest, so the nearest requester after last_grant is written last and wins.
  always_comb begin
    pick = grant;
    for (int i = NUM_CH; i >= 1; i--) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (k == (int'(last_grant) + i) % NUM_CH && s_axis_valid[k])
          pick = CH_W'(k);
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      grant_live <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      grant_live <= grant_live_nxt;
    end
  end

  // grant_live keeps m_axis_data at zero after reset until a channel has actually been granted.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    grant_live_nxt = grant_live;
    fir_clear      = 1'b0;
    busy           = (state != IDLE);
    m_axis_valid   = 1'b0;
    m_axis_last    = 1'b0;
    m_axis_id      = grant;
    m_axis_data    = grant_live ? sel_data : '0;
    s_axis_ready   = '0;
    case (state)
      IDLE: begin
        if (|s_axis_valid) begin
          state_nxt      = CLEAR;
          grant_nxt      = pick;
          grant_live_nxt = 1'b1;
        end
      end
      CLEAR: begin
        fir_clear = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        m_axis_valid = sel_valid;
        m_axis_last  = sel_last;
        for (int k = 0; k < NUM_CH; k++) begin
          if (grant == CH_W'(k))
            s_axis_ready[k] = m_axis_ready;
        end
        if (sel_valid && m_axis_ready && sel_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Directed bench for fir_stream_arbiter: per-channel source queues drive packets, and the expected beats are constants written by hand.
module tb_fir_stream_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int CH_W   = 2;

  logic                     axi_clk = 1'b0;
  logic                     axi_reset_n = 1'b0;
  logic [NUM_CH-1:0]        s_axis_valid = '0;
  logic [NUM_CH*DATA_W-1:0] s_axis_data = '0;
  logic [NUM_CH-1:0]        s_axis_last = '0;
  logic [NUM_CH-1:0]        s_axis_ready;
  logic                     m_axis_valid;
  logic [DATA_W-1:0]        m_axis_data;
  logic                     m_axis_last;
  logic [CH_W-1:0]          m_axis_id;
  logic                     m_axis_ready = 1'b0;
  logic                     fir_clear;
  logic                     busy;

  logic [16:0] src_q [NUM_CH][$];
  int total = 0;
  int bad = 0;

  fir_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
    .s_axis_ready(s_axis_ready), .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data),
    .m_axis_last(m_axis_last), .m_axis_id(m_axis_id), .m_axis_ready(m_axis_ready),
    .fir_clear(fir_clear), .busy(busy)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Each queue head becomes that channel's beat; inputs settle before outputs are sampled.
  task automatic applyStimulus(input logic mready);
    for (int k = 0; k < NUM_CH; k++) begin
      if (src_q[k].size() > 0) begin
        s_axis_valid[k] = 1'b1;
        s_axis_data[k*DATA_W +: DATA_W] = src_q[k][0][15:0];
        s_axis_last[k] = src_q[k][0][16];
      end else begin
        s_axis_valid[k] = 1'b0;
        s_axis_data[k*DATA_W +: DATA_W] = '0;
        s_axis_last[k] = 1'b0;
      end
    end
    m_axis_ready = mready;
    #1;
  endtask

  task automatic advance();
    logic [NUM_CH-1:0] fire;
    fire = s_axis_valid & s_axis_ready;
    @(posedge axi_clk);
    #2;
    for (int k = 0; k < NUM_CH; k++)
      if (fire[k]) void'(src_q[k].pop_front());
  endtask

  task automatic loadPacket(input int ch, input int n, input logic [15:0] base, input logic [15:0] step);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = 16'(int'(base) + int'(step) * i);
      src_q[ch].push_back({(i == n - 1), d});
    end
  endtask

  task automatic doReset();
    axi_reset_n = 1'b0;
    for (int k = 0; k < NUM_CH; k++) src_q[k].delete();
    applyStimulus(1'b0);
    checkOutput("rst_valid", m_axis_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_id", m_axis_id, 0);
    checkOutput("rst_data", m_axis_data, 0);
    @(posedge axi_clk); #2;
    @(posedge axi_clk); #2;
    axi_reset_n = 1'b1;
  endtask

  task automatic waitClear(input int exp_ch);
    int n;
    n = 0;
    applyStimulus(1'b1);
    while (!fir_clear && n < 8) begin
      advance();
      applyStimulus(1'b1);
      n++;
    end
    checkOutput("clear_seen", fir_clear, 1);
    checkOutput("clear_valid", m_axis_valid, 0);
    checkOutput("clear_ready", s_axis_ready, 0);
    checkOutput("clear_busy", busy, 1);
    checkOutput("clear_id", m_axis_id, exp_ch);
    advance();
  endtask

  task automatic beat(input int ch, input logic [15:0] d, input logic l);
    applyStimulus(1'b1);
    checkOutput("beat_valid", m_axis_valid, 1);
    checkOutput("beat_data", m_axis_data, d);
    checkOutput("beat_id", m_axis_id, ch);
    checkOutput("beat_last", m_axis_last, l);
    checkOutput("beat_ready", s_axis_ready, 32'(1) << ch);
    checkOutput("beat_noclear", fir_clear, 0);
    advance();
  endtask

  task automatic stall(input int ch, input logic [15:0] d);
    applyStimulus(1'b0);
    checkOutput("stall_valid", m_axis_valid, 1);
    checkOutput("stall_data", m_axis_data, d);
    checkOutput("stall_id", m_axis_id, ch);
    checkOutput("stall_ready", s_axis_ready, 0);
    checkOutput("stall_busy", busy, 1);
    advance();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();

    // Three-beat packet on ch1 with exact cycle positions.
    loadPacket(1, 3, 16'h0011, 16'h0011);
    applyStimulus(1'b1);
    checkOutput("c0_busy", busy, 0);
    checkOutput("c0_clear", fir_clear, 0);
    advance();
    applyStimulus(1'b1);
    checkOutput("c1_clear", fir_clear, 1);
    checkOutput("c1_valid", m_axis_valid, 0);
    checkOutput("c1_ready", s_axis_ready, 0);
    advance();
    beat(1, 16'h0011, 1'b0);
    beat(1, 16'h0022, 1'b0);
    beat(1, 16'h0033, 1'b1);
    applyStimulus(1'b1);
    checkOutput("c5_busy", busy, 0);
    checkOutput("c5_valid", m_axis_valid, 0);
    checkOutput("c5_last", m_axis_last, 0);
    advance();

    // All channels requesting: grants rotate 0,1,2,3,0.
    doReset();
    for (int k = 0; k < NUM_CH; k++) loadPacket(k, 2, 16'((k + 1) << 8), 16'h0001);
    loadPacket(0, 2, 16'h0500, 16'h0001);
    for (int p = 0; p < 5; p++) begin
      waitClear(p % NUM_CH);
      beat(p % NUM_CH, (p == 4) ? 16'h0500 : 16'(((p % NUM_CH) + 1) << 8), 1'b0);
      beat(p % NUM_CH, (p == 4) ? 16'h0501 : 16'((((p % NUM_CH) + 1) << 8) + 1), 1'b1);
    end

    // Ch0 arrives while ch2 is mid-packet and must wait for ch2's last beat.
    doReset();
    loadPacket(2, 3, 16'h2000, 16'h0001);
    waitClear(2);
    beat(2, 16'h2000, 1'b0);
    loadPacket(0, 2, 16'h0A00, 16'h0001);
    beat(2, 16'h2001, 1'b0);
    beat(2, 16'h2002, 1'b1);
    waitClear(0);
    beat(0, 16'h0A00, 1'b0);
    beat(0, 16'h0A01, 1'b1);

    // Backpressure 1,0,0,1: the stalled beat is presented again, not lost.
    doReset();
    loadPacket(1, 4, 16'h3000, 16'h0001);
    waitClear(1);
    beat(1, 16'h3000, 1'b0);
    stall(1, 16'h3001);
    stall(1, 16'h3001);
    beat(1, 16'h3001, 1'b0);
    beat(1, 16'h3002, 1'b0);
    beat(1, 16'h3003, 1'b1);

    // Reset during beat 2 of 4 on ch3; ch0 must then beat ch3.
    loadPacket(3, 4, 16'h4000, 16'h0001);
    waitClear(3);
    beat(3, 16'h4000, 1'b0);
    applyStimulus(1'b1);
    checkOutput("pre_rst_data", m_axis_data, 16'h4001);
    axi_reset_n = 1'b0;
    #1;
    checkOutput("arst_valid", m_axis_valid, 0);
    checkOutput("arst_last", m_axis_last, 0);
    checkOutput("arst_data", m_axis_data, 0);
    checkOutput("arst_id", m_axis_id, 0);
    checkOutput("arst_ready", s_axis_ready, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_clear", fir_clear, 0);
    src_q[3].delete();
    @(posedge axi_clk); #2;
    @(posedge axi_clk); #2;
    axi_reset_n = 1'b1;
    loadPacket(3, 1, 16'h4100, 16'h0000);
    loadPacket(0, 1, 16'h0B00, 16'h0000);
    waitClear(0);
    beat(0, 16'h0B00, 1'b1);
    waitClear(3);
    beat(3, 16'h4100, 1'b1);

    // Single-beat packet on ch3 completes in one STREAM cycle.
    loadPacket(3, 1, 16'h5555, 16'h0000);
    waitClear(3);
    beat(3, 16'h5555, 1'b1);
    applyStimulus(1'b1);
    checkOutput("single_busy", busy, 0);
    checkOutput("single_valid", m_axis_valid, 0);
    checkOutput("single_last", m_axis_last, 0);
    checkOutput("single_id_hold", m_axis_id, 3);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
